// File: rtl/prom_streamer.sv
// Walks a run of consecutive pROM addresses and streams each byte over valid/ready.
// Absorbs the one-cycle ROM read latency and optionally stops on a terminator byte.
module prom_streamer #(
   parameter int                ADDR_W       = 4,
   parameter int                DATA_W       = 8,
   parameter logic [DATA_W-1:0] TERM         = '0,
   parameter bit                STOP_ON_TERM = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_ad,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic              rom_reset,
   input  logic [DATA_W-1:0] rom_dout,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_READ,
      S_PRESENT,
      S_DONE
   } state_t;

   // The counter is one bit wider so that len==0 can stand for a full 2^ADDR_W run.
   localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_FETCH;
         S_FETCH:   state_d = S_READ;
         S_READ: begin
            if (STOP_ON_TERM && (rom_dout == TERM)) state_d = S_DONE;
            else                                    state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (tx_ready) state_d = (cnt_q == CNT_ONE) ? S_DONE : S_FETCH;
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // abort wins over every other transition, including the DONE pulse
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   always_comb begin
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      if ((state_q == S_IDLE) && start) begin
         addr_d = start_addr;
         cnt_d  = (len == '0) ? CNT_FULL : {1'b0, len};
      end
      if (state_q == S_READ) tx_data_d = rom_dout;
      if ((state_q == S_PRESENT) && tx_ready && !abort) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q - 1'b1;
      end
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      rom_ce   = (state_q == S_FETCH);
      tx_valid = (state_q == S_PRESENT);
   end

   assign rom_ad    = addr_q;
   assign tx_data   = tx_data_q;
   assign rom_oce   = 1'b1;
   assign rom_reset = 1'b0;

endmodule

// File: tb/tb_prom_streamer.sv
// Bench for prom_streamer: two instances (STOP_ON_TERM 0 and 1) share stimulus and are
// checked every cycle against a run-level model built from the ROM contents.
module tb_prom_streamer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort, tx_ready;
   logic [3:0] start_addr, len;

   logic       busy_w [2];
   logic       done_w [2];
   logic [3:0] rom_ad_w [2];
   logic       rom_ce_w [2];
   logic       rom_oce_w [2];
   logic       rom_reset_w [2];
   logic [7:0] rom_dout_w [2];
   logic [7:0] tx_data_w [2];
   logic       tx_valid_w [2];

   logic [7:0] rom [16];
   int         cyc = 0;
   int         vectors = 0;
   int         fails = 0;

   // run-level model state
   bit         m_active [2];
   int         m_fetch [2];
   int         m_done [2];
   int         m_k [2];
   int         m_n [2];
   bit         m_term [2];
   logic [7:0] m_bytes [2][16];
   logic [3:0] m_addrs [2][17];

   // observation log used by the directed literal checks
   int         obs_n [2];
   logic [7:0] obs_byte [2][32];
   int         hs_at [2][32];
   int         rise_n [2];
   int         rise_at [2][32];
   int         ce_cnt [2];
   logic [3:0] ad_log [2][32];
   int         done_cnt [2];
   int         done_at [2];
   int         busy_fall [2];
   bit         pv [2];
   bit         pb [2];

   always #5 clk = ~clk;

   prom_streamer #(.ADDR_W(4), .DATA_W(8), .TERM(8'h00), .STOP_ON_TERM(1'b0)) u_dut_nostop (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
      .abort(abort), .busy(busy_w[0]), .done(done_w[0]), .rom_ad(rom_ad_w[0]),
      .rom_ce(rom_ce_w[0]), .rom_oce(rom_oce_w[0]), .rom_reset(rom_reset_w[0]),
      .rom_dout(rom_dout_w[0]), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
      .tx_ready(tx_ready)
   );

   prom_streamer #(.ADDR_W(4), .DATA_W(8), .TERM(8'h00), .STOP_ON_TERM(1'b1)) u_dut_stop (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
      .abort(abort), .busy(busy_w[1]), .done(done_w[1]), .rom_ad(rom_ad_w[1]),
      .rom_ce(rom_ce_w[1]), .rom_oce(rom_oce_w[1]), .rom_reset(rom_reset_w[1]),
      .rom_dout(rom_dout_w[1]), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
      .tx_ready(tx_ready)
   );

   // synchronous ROMs with one-cycle latency on the rom_ce edge
   always @(posedge clk) if (rom_ce_w[0]) rom_dout_w[0] <= rom[rom_ad_w[0]];
   always @(posedge clk) if (rom_ce_w[1]) rom_dout_w[1] <= rom[rom_ad_w[1]];

   initial begin
      for (int a = 0; a < 16; a++) begin
         if (a <= 8)       rom[a] = 8'h41 + 8'(a);
         else if (a <= 14) rom[a] = 8'h50 + 8'(a - 9);
         else              rom[a] = 8'h00;
      end
      rom_dout_w[0] = 8'h00;
      rom_dout_w[1] = 8'h00;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", nm, i, cyc, act, exp);
      end
   endtask

   // expected byte list of a run, straight from the ROM and the stop rule
   task automatic build(input int i, input logic [3:0] sa, input logic [3:0] ln);
      int         l;
      logic [3:0] a;
      l = (ln == 4'd0) ? 16 : int'(ln);
      m_n[i] = l;
      m_term[i] = 1'b0;
      for (int j = 0; j < l; j++) begin
         a = sa + 4'(j);
         m_addrs[i][j] = a;
         if ((i == 1) && (rom[a] == 8'h00)) begin
            m_term[i] = 1'b1;
            m_n[i] = j;
            break;
         end
         m_bytes[i][j] = rom[a];
      end
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 2; i++) begin
         obs_n[i] = 0; rise_n[i] = 0; ce_cnt[i] = 0;
         done_cnt[i] = 0; done_at[i] = -1; busy_fall[i] = -1;
      end
   endtask

   // compare process: each negedge checks the current cycle, then advances the model
   initial begin
      bit e_busy, e_done, e_ce, e_valid;
      int c;
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0; m_done[i] = -1; pv[i] = 1'b0; pb[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         c = cyc;
         for (int i = 0; i < 2; i++) begin
            chk("rom_oce", i, rom_oce_w[i], 1);
            chk("rom_reset", i, rom_reset_w[i], 0);
            if (!rst_n) begin
               m_active[i] = 1'b0;
               m_done[i] = -1;
               pv[i] = 1'b0;
               pb[i] = 1'b0;
               chk("rst_busy", i, busy_w[i], 0);
               chk("rst_done", i, done_w[i], 0);
               chk("rst_valid", i, tx_valid_w[i], 0);
               chk("rst_ce", i, rom_ce_w[i], 0);
               chk("rst_ad", i, rom_ad_w[i], 0);
               chk("rst_data", i, tx_data_w[i], 0);
            end else begin
               e_busy  = m_active[i] || (c == m_done[i]);
               e_done  = (c == m_done[i]);
               e_ce    = m_active[i] && (c == m_fetch[i]);
               e_valid = m_active[i] && (m_k[i] < m_n[i]) && (c >= m_fetch[i] + 2);
               chk("busy", i, busy_w[i], e_busy);
               chk("done", i, done_w[i], e_done);
               chk("rom_ce", i, rom_ce_w[i], e_ce);
               chk("tx_valid", i, tx_valid_w[i], e_valid);
               if (e_ce) chk("fetch_ad", i, rom_ad_w[i], m_addrs[i][m_k[i]]);
               if (e_valid) begin
                  chk("tx_data", i, tx_data_w[i], m_bytes[i][m_k[i]]);
                  chk("present_ad", i, rom_ad_w[i], m_addrs[i][m_k[i]]);
               end
               if (tx_valid_w[i] && !pv[i] && rise_n[i] < 32) rise_at[i][rise_n[i]++] = c;
               if (tx_valid_w[i] && tx_ready && !abort && obs_n[i] < 32) begin
                  obs_byte[i][obs_n[i]] = tx_data_w[i];
                  hs_at[i][obs_n[i]] = c;
                  obs_n[i]++;
               end
               if (rom_ce_w[i] && ce_cnt[i] < 32) ad_log[i][ce_cnt[i]] = rom_ad_w[i];
               if (rom_ce_w[i]) ce_cnt[i]++;
               if (done_w[i]) begin done_cnt[i]++; done_at[i] = c; end
               if (pb[i] && !busy_w[i]) busy_fall[i] = c;
               pv[i] = tx_valid_w[i];
               pb[i] = busy_w[i];

               if (abort && e_busy) begin
                  m_active[i] = 1'b0;
                  m_done[i] = -1;
               end else if (!e_busy) begin
                  if (start) begin
                     build(i, start_addr, len);
                     m_active[i] = 1'b1;
                     m_k[i] = 0;
                     m_fetch[i] = c + 1;
                     m_done[i] = (m_n[i] == 0) ? c + 3 : -1;
                  end
               end else if (e_valid && tx_ready) begin
                  m_k[i]++;
                  m_fetch[i] = c + 1;
                  if (m_k[i] == m_n[i]) m_done[i] = m_term[i] ? c + 3 : c + 1;
               end
               if (m_done[i] == c + 1) m_active[i] = 1'b0;
            end
         end
      end
   end

   task automatic do_start(input logic [3:0] sa, input logic [3:0] l, output int e0);
      start = 1'b1; start_addr = sa; len = l;
      e0 = cyc + 1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy_w[0] || busy_w[1]) && n < lim);
      chk("idle_wait", 0, {31'd0, busy_w[0] | busy_w[1]}, 0);
      @(posedge clk); #2;
   endtask

   task automatic wait_valid(input int i, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (!tx_valid_w[i] && n < lim);
      chk("valid_wait", i, tx_valid_w[i], 1);
   endtask

   task automatic chk_bytes(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
      chk("nbytes", i, obs_n[i], n);
      if (n > 0) chk("byte0", i, obs_byte[i][0], b0);
      if (n > 1) chk("byte1", i, obs_byte[i][1], b1);
      if (n > 2) chk("byte2", i, obs_byte[i][2], b2);
   endtask

   initial begin
      int e0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
      start_addr = 4'd0; len = 4'd0;
      clear_obs();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;

      // basic run with pinned timing
      clear_obs(); tx_ready = 1'b1;
      do_start(4'd0, 4'd3, e0);
      wait_idle(60);
      for (int i = 0; i < 2; i++) begin
         chk_bytes(i, 3, 8'h41, 8'h42, 8'h43);
         chk("rise0", i, rise_at[i][0] - e0, 2);
         chk("rise1", i, rise_at[i][1] - e0, 5);
         chk("rise2", i, rise_at[i][2] - e0, 8);
         chk("done_cnt", i, done_cnt[i], 1);
         chk("done_at", i, done_at[i] - e0, 9);
         chk("busy_fall", i, busy_fall[i] - e0, 10);
      end

      // terminator stop (instance 1); instance 0 streams all 16
      clear_obs();
      do_start(4'd13, 4'd0, e0);
      wait_idle(120);
      chk_bytes(1, 2, 8'h54, 8'h55, 8'h00);
      chk("term_ce", 1, ce_cnt[1], 3);
      chk("term_done", 1, done_cnt[1], 1);
      chk("full_n", 0, obs_n[0], 16);

      // backpressure on the first byte
      clear_obs(); tx_ready = 1'b0;
      do_start(4'd2, 4'd2, e0);
      wait_valid(0, 20);
      repeat (5) @(posedge clk);
      #2 tx_ready = 1'b1;
      wait_idle(60);
      for (int i = 0; i < 2; i++) begin
         chk_bytes(i, 2, 8'h43, 8'h44, 8'h00);
         chk("stall_len", i, hs_at[i][0] - rise_at[i][0], 5);
         chk("bp_ce", i, ce_cnt[i], 2);
      end

      // address wrap
      clear_obs();
      do_start(4'd14, 4'd3, e0);
      wait_idle(60);
      chk_bytes(0, 3, 8'h55, 8'h00, 8'h41);
      chk("wrap_ad0", 0, ad_log[0][0], 14);
      chk("wrap_ad1", 0, ad_log[0][1], 15);
      chk("wrap_ad2", 0, ad_log[0][2], 0);
      chk_bytes(1, 1, 8'h55, 8'h00, 8'h00);

      // start while busy is ignored, then abort
      clear_obs(); tx_ready = 1'b0;
      do_start(4'd0, 4'd5, e0);
      wait_valid(0, 20);
      @(posedge clk); #2;
      start = 1'b1; start_addr = 4'd7; len = 4'd1;
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         chk("abort_busy", i, busy_w[i], 0);
         chk("abort_valid", i, tx_valid_w[i], 0);
      end
      #1 abort = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("abort_done", i, done_cnt[i], 0);
         chk("abort_bytes", i, obs_n[i], 0);
      end
      @(posedge clk); #2;
      clear_obs(); tx_ready = 1'b1;
      do_start(4'd9, 4'd2, e0);
      wait_idle(60);
      for (int i = 0; i < 2; i++) begin
         chk_bytes(i, 2, 8'h50, 8'h51, 8'h00);
         chk("restart_done", i, done_cnt[i], 1);
      end

      // asynchronous reset during READ
      do_start(4'd0, 4'd4, e0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("arst_busy", i, busy_w[i], 0);
         chk("arst_ce", i, rom_ce_w[i], 0);
         chk("arst_ad", i, rom_ad_w[i], 0);
         chk("arst_data", i, tx_data_w[i], 0);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      clear_obs();
      repeat (6) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_valid", i, rise_n[i], 0);
         chk("post_rst_done", i, done_cnt[i], 0);
      end
      @(posedge clk); #2;
      do_start(4'd5, 4'd2, e0);
      wait_idle(60);
      for (int i = 0; i < 2; i++) chk_bytes(i, 2, 8'h46, 8'h47, 8'h00);

      // randomized traffic, checked by the per-cycle model
      for (int n = 0; n < 3000; n++) begin
         start      = ($urandom_range(0, 5) == 0);
         start_addr = 4'($urandom_range(0, 15));
         len        = 4'($urandom_range(0, 15));
         abort      = ($urandom_range(0, 59) == 0);
         tx_ready   = ($urandom_range(0, 3) != 0);
         rst_n      = ($urandom_range(0, 799) != 0);
         @(posedge clk); #2;
      end
      start = 1'b0; abort = 1'b0; tx_ready = 1'b1; rst_n = 1'b1;
      wait_idle(200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/prom_streamer.md
# prom_streamer

Sequencer for the 16×8 synchronous pROM: on a start request it walks a run of consecutive ROM addresses, absorbs the one-cycle ROM read latency, and streams each byte to a downstream consumer (typically the UART transmitter) over a valid/ready handshake. It sits between the control logic that selects a message and the ROM primitive, and is the only block that drives the ROM's address and enable pins.

## Interface
- ADDR_W, 4: ROM address width.
- DATA_W, 8: ROM data width.
- TERM, 8'h00: terminator byte value.
- STOP_ON_TERM, 1: 1 = end the run on reading TERM, without emitting it; 0 = TERM is ordinary data.

- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- start_addr  in  ADDR_W  first ROM address; latched with start.
- len  in  ADDR_W  byte count; 0 means 2^ADDR_W (16).
- abort  in  1  cancel the current run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run ends normally.
- rom_ad  out  ADDR_W  ROM address.
- rom_ce  out  1  ROM clock enable (read strobe).
- rom_oce  out  1  ROM output enable; constant 1.
- rom_reset  out  1  ROM sync reset; constant 0.
- rom_dout  in  DATA_W  ROM read data, valid the cycle after the rom_ce edge.
- tx_data  out  DATA_W  byte to consumer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  consumer accepts the byte.

## Operation
- States: IDLE, FETCH, READ, PRESENT, DONE.
- IDLE: busy=0. On start=1: latch addr<=start_addr and cnt<=len (0 loads 16), then go to FETCH.
- FETCH: rom_ce=1 and rom_ad=addr for exactly one cycle, then go to READ.
- READ: capture rom_dout into the tx_data register.
  - If STOP_ON_TERM and rom_dout==TERM, go to DONE and emit nothing.
  - Otherwise go to PRESENT.
- PRESENT: tx_valid=1. tx_data is held stable until the handshake (tx_valid && tx_ready). On the handshake:
  - addr<=addr+1, wrapping 15→0.
  - cnt<=cnt-1.
  - If cnt==1, go to DONE; else go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in FETCH, READ, PRESENT and DONE.
- rom_ce is 0 outside FETCH. rom_ad holds addr in every state.
- abort=1 in any non-IDLE state: go to IDLE at the next edge with no done pulse. tx_valid drops even if no handshake occurred. abort has priority over every other transition.
- start is ignored while busy.
- A start arriving in the DONE cycle is ignored. It is sampled again once the block is in IDLE.
- Wrap-around is legal: a run may span address 15→0.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): IDLE state, busy=0, done=0, tx_valid=0, tx_data=0, rom_ce=0, rom_ad=0, addr=0, cnt=0. rom_oce=1 and rom_reset=0 at all times.
- Reset asserted mid-run: the run is lost and outputs take their reset values at once. After release, the block waits in IDLE for a new start.
- Latency, with start sampled at edge E0:
  - FETCH during cycle E0→E1.
  - READ during E1→E2.
  - tx_valid=1 from E2.
- Throughput with tx_ready held high: one byte every 3 cycles.
- done is asserted the cycle after the final handshake, or the cycle after the terminator READ.
- Backpressure: each cycle with tx_ready=0 in PRESENT adds exactly one cycle. No extra rom_ce is issued during the stall.

## Test plan
Bench ROM model holds 0x41..0x49 at addresses 0..8, 0x50..0x55 at 9..14, and 0x00 at 15. The model has 1-cycle read latency on the rom_ce edge.

1. Basic run: start_addr=0, len=3, tx_ready=1 → bytes 0x41, 0x42, 0x43. tx_valid rises at E2, E5, E8. done pulses once at E9. busy falls at E10.
2. Terminator stop: STOP_ON_TERM=1, start_addr=13, len=0 → bytes 0x54, 0x55 only. The address-15 read returns 0x00, which is not emitted, and done pulses. Exactly 3 rom_ce pulses.
3. Backpressure: start_addr=2, len=2, tx_ready low for 5 cycles on the first byte → tx_data holds 0x43 with tx_valid high throughout. Then 0x44 follows. Exactly 2 rom_ce pulses.
4. Wrap: STOP_ON_TERM=0, start_addr=14, len=3 → bytes 0x55, 0x00, 0x41, with rom_ad sequence 14, 15, 0.
5. Start while busy, then abort: second start during PRESENT is ignored. abort in PRESENT → IDLE next cycle, tx_valid=0, no done. A new start then runs normally from its own start_addr.
6. Async reset: rst_n pulsed low mid-READ → all outputs take their reset values before the next clk edge. No tx_valid or done after release until a new start.
